// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants for the execute-stage ALU issue arbiter.
package alu_issue_arbiter_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_vld
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_vld && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = ID_W'(j);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of one ALU: issue register feeds the ALU, response
// register captures its result; backpressure from rsp_ready stalls both.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ALU_DATA_W-1:0] req_operand1,
  input  logic [NUM_REQ*ALU_DATA_W-1:0] req_operand2,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_alu_op,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  output logic [ALU_DATA_W-1:0]         alu_operand1,
  output logic [ALU_DATA_W-1:0]         alu_operand2,
  output logic [ALU_OP_W-1:0]           alu_op,
  input  logic [ALU_DATA_W-1:0]         alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ALU_DATA_W-1:0]         rsp_result,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
);

  typedef struct packed {
    logic [ALU_DATA_W-1:0] op1;
    logic [ALU_DATA_W-1:0] op2;
    logic [ALU_OP_W-1:0]   op;
    logic [TAG_W-1:0]      tag;
    logic [ID_W-1:0]       id;
  } iss_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic [TAG_W-1:0]      tag;
    logic [ID_W-1:0]       id;
  } rsp_t;

  iss_t             iss_q, iss_d;
  rsp_t             rsp_q, rsp_d;
  logic             iss_valid_q, iss_valid_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               rsp_adv, iss_free, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // rsp_ready reaches req_ready only through iss_free.
  assign rsp_adv   = iss_valid_q & (~rsp_valid_q | rsp_ready);
  assign iss_free  = ~iss_valid_q | rsp_adv;
  assign accept    = gnt_vld & iss_free;
  assign req_ready = gnt & {NUM_REQ{iss_free}};

  always_comb begin
    iss_d       = iss_q;
    iss_valid_d = iss_valid_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;

    if (accept) begin
      iss_d.op1   = req_operand1[gnt_idx*ALU_DATA_W +: ALU_DATA_W];
      iss_d.op2   = req_operand2[gnt_idx*ALU_DATA_W +: ALU_DATA_W];
      iss_d.op    = req_alu_op[gnt_idx*ALU_OP_W +: ALU_OP_W];
      iss_d.tag   = req_tag[gnt_idx*TAG_W +: TAG_W];
      iss_d.id    = gnt_idx;
      iss_valid_d = 1'b1;
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_adv) begin
      iss_valid_d = 1'b0;
    end

    if (rsp_adv) begin
      rsp_d.result = alu_result;
      rsp_d.tag    = iss_q.tag;
      rsp_d.id     = iss_q.id;
      rsp_valid_d  = 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign alu_operand1 = iss_q.op1;
  assign alu_operand2 = iss_q.op2;
  assign alu_op       = iss_q.op;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_q.result;
  assign rsp_tag      = rsp_q.tag;
  assign rsp_id       = rsp_q.id;
  assign busy         = iss_valid_q | rsp_valid_q;

endmodule
